// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control sequencer.
// Holds the FSM state encoding, the operation-kind encoding and the
// {btnl,btnc,btnr} -> alu_op code table.
package calc_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPND_W   = 16;
  localparam int unsigned SEL_W    = 3;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [STATE_W-1:0] ST_EXEC     = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD     = 2'd3;

  // Kind of operation being debounced
  localparam logic KIND_UPDATE = 1'b0;
  localparam logic KIND_CLEAR  = 1'b1;

  // ALU operation codes indexed by {l,c,r}
  localparam logic [ALU_OP_W-1:0] ALU_LCR_000 = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_001 = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_010 = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_011 = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_100 = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_101 = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_110 = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_LCR_111 = 4'b1011;

  // Map synced select buttons to the ALU operation code
  function automatic logic [ALU_OP_W-1:0] alu_code(input logic [SEL_W-1:0] lcr);
    logic [ALU_OP_W-1:0] code;
    case (lcr)
      3'b000:  code = ALU_LCR_000;
      3'b001:  code = ALU_LCR_001;
      3'b010:  code = ALU_LCR_010;
      3'b011:  code = ALU_LCR_011;
      3'b100:  code = ALU_LCR_100;
      3'b101:  code = ALU_LCR_101;
      3'b110:  code = ALU_LCR_110;
      default: code = ALU_LCR_111;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// 2-flop synchronizer with rising-edge detect for one raw button.
// Ports: clk, rst_n; btn_i raw async button; sync_o synced level;
// rise_c one-cycle rise indication (combinational from flops).
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic sync_o,
  output logic rise_c
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] vld_q, vld_d;

  // vld tracks when sync_q holds a real sample rather than reset zeros;
  // armed requires a genuine low so a button held through reset never rises.
  always_comb begin
    meta_d  = btn_i;
    sync_d  = meta_q;
    prev_d  = sync_q;
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ~sync_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_c = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/calc_sequencer.sv
// Button-driven control sequencer for the calculator datapath.
// Debounces the update (btnd) and clear (btnu) buttons and emits one
// accumulator strobe per press, capturing operand and ALU op on update.
// Ports: clk, rst_n; btnd/btnu/btnl/btnc/btnr raw buttons; sw raw operand;
// alu_op, op2_q captured op/operand; acc_we/acc_clr strobes; busy.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btnd,
  input  logic                btnu,
  input  logic                btnl,
  input  logic                btnc,
  input  logic                btnr,
  input  logic [OPND_W-1:0]   sw,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [OPND_W-1:0]   op2_q,
  output logic                acc_we,
  output logic                acc_clr,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             d_sync, d_rise, u_sync, u_rise;
  logic             l_sync, c_sync, r_sync;
  logic [SEL_W-1:0] sel_rise_unused;

  btn_sync u_btnd (.clk(clk), .rst_n(rst_n), .btn_i(btnd), .sync_o(d_sync), .rise_c(d_rise));
  btn_sync u_btnu (.clk(clk), .rst_n(rst_n), .btn_i(btnu), .sync_o(u_sync), .rise_c(u_rise));
  btn_sync u_btnl (.clk(clk), .rst_n(rst_n), .btn_i(btnl), .sync_o(l_sync), .rise_c(sel_rise_unused[2]));
  btn_sync u_btnc (.clk(clk), .rst_n(rst_n), .btn_i(btnc), .sync_o(c_sync), .rise_c(sel_rise_unused[1]));
  btn_sync u_btnr (.clk(clk), .rst_n(rst_n), .btn_i(btnr), .sync_o(r_sync), .rise_c(sel_rise_unused[0]));

  logic [OPND_W-1:0]   sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                kind_q, kind_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [OPND_W-1:0]   op2_d;
  logic                acc_we_q, acc_we_d;
  logic                acc_clr_q, acc_clr_d;
  logic                busy_q, busy_d;
  logic                btn_hi;

  // Next-state, capture and strobe logic
  always_comb begin
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    alu_op_d  = alu_op_q;
    op2_d     = op2_q;
    acc_we_d  = 1'b0;
    acc_clr_d = 1'b0;
    btn_hi    = (kind_q == KIND_CLEAR) ? u_sync : d_sync;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (u_rise) begin
          state_d = ST_DEBOUNCE;
          kind_d  = KIND_CLEAR;
        end else if (d_rise) begin
          state_d = ST_DEBOUNCE;
          kind_d  = KIND_UPDATE;
        end
      end
      ST_DEBOUNCE: begin
        // A clear press pre-empts an update still being debounced
        if ((kind_q == KIND_UPDATE) && u_rise) begin
          cnt_d  = '0;
          kind_d = KIND_CLEAR;
        end else if (!btn_hi) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_EXEC;
          if (kind_q == KIND_UPDATE) begin
            acc_we_d = 1'b1;
            op2_d    = sw_sync_q;
            alu_op_d = alu_code({l_sync, c_sync, r_sync});
          end else begin
            acc_clr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!d_sync && !u_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      kind_q    <= KIND_UPDATE;
      alu_op_q  <= '0;
      op2_q     <= '0;
      acc_we_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      alu_op_q  <= alu_op_d;
      op2_q     <= op2_d;
      acc_we_q  <= acc_we_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign acc_we  = acc_we_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 500000, number of cycles a button must stay high to count as a press; legal range is DB_CYCLES >= 1.
REQ-002 clk  input  1  single system clock; all flops on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 btnd  input  1  raw update button (asynchronous).
REQ-005 btnu  input  1  raw clear button (asynchronous).
REQ-006 btnl, btnc, btnr  input  1 each  raw operation-select buttons (asynchronous).
REQ-007 sw  input  16  raw operand switches.
REQ-008 alu_op  output  4  registered ALU operation code, stable between captures.
REQ-009 op2_q  output  16  registered operand, sampled from sw at capture.
REQ-010 acc_we  output  1  one-cycle accumulator load strobe.
REQ-011 acc_clr  output  1  one-cycle accumulator clear strobe.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 All five buttons pass through a 2-flop synchronizer; rise = sync high AND previous sync low.
REQ-014 The FSM has four states: IDLE, DEBOUNCE, EXEC, HOLD.
REQ-015 IDLE: on a rise of btnu or btnd, go to DEBOUNCE, clear the counter, and record the kind (clear if btnu rose, else update); btnu wins if both rise together.
REQ-016 DEBOUNCE: the counter increments each cycle while the recorded button stays synced-high; if it drops, return to IDLE with no strobe.
REQ-017 DEBOUNCE: on a btnu rise while the recorded kind is update, restart the counter with kind = clear.
REQ-018 DEBOUNCE: when the counter equals DB_CYCLES-1 with the button still high, go to EXEC.
REQ-019 On that same transition, update kind latches op2_q <= synced sw and alu_op <= code from synced {btnl,btnc,btnr}; clear kind leaves both unchanged.
REQ-020 alu_op map {l,c,r}: 000->0000, 001->0011, 010->0010, 011->0011, 100->0100, 101->0111, 110->0001, 111->1011.
REQ-021 EXEC lasts exactly one cycle: acc_we=1 (update) or acc_clr=1 (clear), never both; then go to HOLD.
REQ-022 HOLD: stay until synced btnd and btnu are both low, then go to IDLE; a held button never produces a second strobe.
REQ-023 Latency: with raw btnd first sampled high at edge 0 and held, acc_we is high for the single cycle following edge DB_CYCLES+2.
REQ-024 btnl/btnc/btnr/sw changes outside the capture edge have no effect on alu_op or op2_q.
REQ-025 Counter width is clog2(DB_CYCLES)+1 bits; it never wraps, because it holds at DB_CYCLES-1 until the state exits.

Reset
REQ-026 rst_n low forces, immediately and asynchronously: state=IDLE, counter=0, sync flops=0, alu_op=0000, op2_q=0, acc_we=0, acc_clr=0, busy=0.
REQ-027 Reset mid-DEBOUNCE or mid-EXEC aborts the operation; no strobe follows reset release.
REQ-028 After release, a button already held high does not register a rise until it is seen low and then high again.

Structure
REQ-029 Shared package calc_pkg holds the FSM state encoding, the eight alu_op codes of REQ-020 and the kind encoding.
REQ-030 Sub-module btn_sync (2-flop synchronizer plus rise detect) is instantiated once per button; sw uses a plain 16-bit 2-flop synchronizer.
REQ-031 Outputs connect directly to the existing calculator datapath: acc_we/acc_clr replace the btnd/btnu accumulator controls; alu_op drives the ALU.

Verification (DB_CYCLES=4)
REQ-032 r=1, l=c=0, sw=16'h0005, btnd high 10 cycles -> alu_op=0011, op2_q=0005, one acc_we pulse after edge 6, busy high until release.
REQ-033 btnd high for 2 cycles -> no acc_we or acc_clr; returns to IDLE; alu_op unchanged.
REQ-034 btnd and btnu rise in the same cycle, both held -> exactly one acc_clr, zero acc_we, alu_op unchanged.
REQ-035 btnd held 100 cycles -> exactly one acc_we; busy high until release plus sync delay.
REQ-036 rst_n pulsed low during DEBOUNCE with btnd still held -> all outputs 0 at once, and no strobe until btnd is released and pressed again.
REQ-037 Sweep all 8 {l,c,r} combinations with a valid btnd press each -> alu_op matches the REQ-020 table.
